// File: rtl/data_memory_if.sv
// Load/store bus between the controller and the data-memory responder.
// The controller holds MemRead/MemWrite stable until busy drops.
interface data_memory_if #(
  parameter int unsigned NBITS = 8
);
  logic             MemRead;
  logic             MemWrite;
  logic [NBITS-1:0] Address;
  logic [NBITS-1:0] WriteData;
  logic [NBITS-1:0] ReadData;
  logic             busy;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, busy
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, busy
  );
endinterface

// File: rtl/data_memory.sv
// Data-memory responder: services loads/stores against a word array with a
// fixed LATENCY-cycle busy window followed by a one-cycle response.
module data_memory #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clock,
  input  logic          reset,
  data_memory_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** NBITS;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] addr_q, wdata_q, rdata_q;
  logic             we_q;
  logic [NBITS-1:0] mem_q [DEPTH];

  logic             req_c, busy_c, latch_c, access_c, acc_we_c;
  logic [NBITS-1:0] acc_addr_c, acc_data_c;

  assign req_c = bus.MemRead | bus.MemWrite;

  // Next-state logic; while reset is high nothing is accepted and busy stays low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_c     = 1'b0;
    latch_c    = 1'b0;
    access_c   = 1'b0;
    acc_addr_c = addr_q;
    acc_data_c = wdata_q;
    acc_we_c   = we_q;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          busy_c = req_c;
          if (req_c) begin
            latch_c = 1'b1;
            cnt_d   = CW'(LATENCY - 1);
            if (LATENCY == 1) begin
              // Single-cycle access uses the request inputs directly.
              access_c   = 1'b1;
              acc_addr_c = bus.Address;
              acc_data_c = bus.WriteData;
              acc_we_c   = bus.MemWrite;
              state_d    = RESP;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          busy_c = 1'b1;
          if (cnt_q == CW'(1)) begin
            access_c = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RESP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_c) begin
        addr_q  <= bus.Address;
        wdata_q <= bus.WriteData;
        we_q    <= bus.MemWrite;
      end
      if (access_c && !acc_we_c) begin
        rdata_q <= mem_q[acc_addr_c];
      end
    end
  end

  // Array contents survive reset; an access aborted by reset never commits.
  always_ff @(posedge clock) begin
    if (access_c && acc_we_c) begin
      mem_q[acc_addr_c] <= acc_data_c;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.busy     = busy_c;

endmodule
